axi_lite_sram: RTL and testbench
================================

# axi_lite_sram

AXI4-Lite slave memory that sits directly downstream of the NPC bus arbiter and serves both the IF instruction-fetch master and the MEM load/store master. It has a 64-bit data path, byte-strobed writes and a programmable access latency, so the core's fetch/LSU handshakes (`inst_update` / `mem_finish`) can be exercised under realistic multi-cycle memory delay. It has a single port: one transaction, read or write, is in flight at a time.

## Interface
Parameters:
- `BASE`, 32'h8000_0000, first byte address served
- `DEPTH`, 4096, number of 64-bit words
- `LAT`, 2, extra wait cycles per access (0..15)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `araddr`  in  32  read address
- `arvalid`  in  1  read address valid
- `arready`  out  1  read address ready
- `rdata`  out  64  read data
- `rresp`  out  2  read response
- `rvalid`  out  1  read data valid
- `rready`  in  1  read data ready
- `awaddr`  in  32  write address
- `awvalid`  in  1  write address valid
- `awready`  out  1  write address ready
- `wdata`  in  64  write data
- `wstrb`  in  8  byte strobes; bit i enables `wdata[8i+7:8i]`
- `wvalid`  in  1  write data valid
- `wready`  out  1  write data ready
- `bresp`  out  2  write response
- `bvalid`  out  1  write response valid
- `bready`  in  1  write response ready

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- IDLE: `arready` = read granted; `awready` = `wready` = write granted. A write is eligible only when `awvalid` && `wvalid` are both high (AW and W accepted in the same cycle).
- Grant: if only one side is eligible, that side wins. If both are eligible, the side not served last wins (1-bit `last_was_rd` register, reset value 1, so the first tie goes to the write).
- AR handshake: latch `araddr`, load counter with `LAT`, go to RD_WAIT. When the counter is 0, read the array, register `rdata`/`rresp`, go to RD_RESP. In RD_RESP `rvalid`=1 and `rdata`/`rresp` hold stable until `rready`; on `rvalid`&&`rready` go to IDLE.
- AW/W handshake: latch addr/data/strb, go to WR_WAIT with counter=`LAT`. When the counter is 0, commit the masked write and go to WR_RESP. In WR_RESP `bvalid`=1 until `bready`, then go to IDLE.
- Address decode: word index = (addr − `BASE`) >> 3. The low 3 address bits are ignored (the 64-bit word is aligned and strobes select bytes). An address outside [`BASE`, `BASE`+`DEPTH`*8) gets resp SLVERR (2'b10): `rdata`=0 and no array write. In-range accesses get OKAY (2'b00).
- `wstrb`=0 → no bytes change, resp OKAY.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE, `arvalid`-side and `awvalid`-side outputs `arready`/`awready`/`wready`/`rvalid`/`bvalid` = 0 while `rst` is low, `rdata`=0, `rresp`=`bresp`=2'b00, counter 0, `last_was_rd`=1. Array contents are not reset.
- Reset mid-transaction aborts it. A write still in WR_WAIT is not committed; a write already in WR_RESP stays committed.
- Read latency: `rvalid` rises `LAT`+1 cycles after the AR handshake edge. With `LAT`=0, `rvalid` is high in the cycle after the handshake.
- Write latency: the array is updated and `bvalid` rises `LAT`+1 cycles after the AW/W handshake edge.
- Back-to-back: IDLE is re-entered the cycle after the R/B handshake. Minimum of `LAT`+3 cycles per transaction; no overlap.
- A read following a write to the same address returns the new data.
- Ready signals are combinational from state and the valids. Valid/data/resp outputs are registered.

## Structure
- `npc_axi_pkg`: holds `RESP_OKAY`, `RESP_SLVERR`, the FSM state enum, and the address/data/strobe width constants shared with the arbiter and masters.
- Sub-module `axi_sram_array`: a `DEPTH`×64 synchronous array with one read port and one byte-masked write port. The FSM, counter and decode stay in the top.

## Test plan
- `LAT`=2, write 0x1122334455667788 @0x8000_0010 with strb 0xFF, then read the same address → `bvalid` 3 cycles after AW/W; `rdata`=0x1122334455667788, `rresp`=0, `rvalid` 3 cycles after AR.
- Write 0xAAAA… with strb 0x0F over the previous value, then read back → 0x11223344AAAAAAAA.
- `arvalid`, `awvalid` and `wvalid` all high from reset → the write is granted first and the read second. Then repeat with persistent contention → grants alternate R, W, R, W.
- Read @0x7FFF_FFF8 and write @`BASE`+`DEPTH`*8 → `rresp`=2'b10 with `rdata`=0, `bresp`=2'b10, and a following read of `BASE` shows it unchanged.
- Hold `rready`=0 for 5 cycles after `rvalid` → `rvalid`/`rdata` stay stable and `arready`=0 throughout. Repeat with `bready`=0 → `bvalid` holds and `awready`=0.
- Assert `rst`=0 during WR_WAIT, then read the target → old value returned. Check all outputs match their reset values in the cycle after the reset edge.

Source files
------------

// File: rtl/npc_axi_pkg.sv
// Shared AXI4-Lite constants and types for the NPC bus, its arbiter and masters.
package npc_axi_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_e;
endpackage

// File: rtl/axi_sram_array.sv
// DEPTH x 64 synchronous memory: one registered read port, one byte-masked write port.
module axi_sram_array
    import npc_axi_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        rd_data_q <= mem[rd_idx];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/axi_lite_sram.sv
// Single-outstanding AXI4-Lite slave memory with a programmable wait-state count,
// serving the IF and MEM masters behind the NPC arbiter.
module axi_lite_sram
    import npc_axi_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE  = 32'h8000_0000,
    parameter int                DEPTH = 4096,
    parameter int                LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);
    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 8);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE) && ((a - BASE) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 3);
    endfunction

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                last_rd_q, last_rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rvalid_q, rvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                bvalid_q, bvalid_d;

    logic                wr_elig, grant_rd, grant_wr, addr_ok, arr_we;
    logic [IDX_W-1:0]    arr_rd_idx;
    logic [DATA_W-1:0]   arr_rdata;

    // Ties go to whichever side was not served last.
    assign wr_elig  = awvalid && wvalid;
    assign grant_rd = rst && (state_q == IDLE) && arvalid && (!wr_elig || !last_rd_q);
    assign grant_wr = rst && (state_q == IDLE) && wr_elig && (!arvalid || last_rd_q);
    assign arready  = grant_rd;
    assign awready  = grant_wr;
    assign wready   = grant_wr;

    assign addr_ok    = in_range(addr_q);
    assign arr_we     = rst && (state_q == WR_WAIT) && (cnt_q == 4'd0) && addr_ok;
    // Steer the live araddr in IDLE so the word is ready even when LAT is 0.
    assign arr_rd_idx = (state_q == IDLE) ? idx_of(araddr) : idx_of(addr_q);

    axi_sram_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .rd_idx  (arr_rd_idx),
        .rd_data (arr_rdata),
        .we      (arr_we),
        .wr_idx  (idx_of(addr_q)),
        .wr_data (wdata_q),
        .wr_strb (wstrb_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rvalid_d  = rvalid_q;
        bresp_d   = bresp_q;
        bvalid_d  = bvalid_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    addr_d    = awaddr;
                    wdata_d   = wdata;
                    wstrb_d   = wstrb;
                    cnt_d     = 4'(LAT);
                    last_rd_d = 1'b0;
                    state_d   = WR_WAIT;
                end else if (grant_rd) begin
                    addr_d    = araddr;
                    cnt_d     = 4'(LAT);
                    last_rd_d = 1'b1;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d  = addr_ok ? arr_rdata : '0;
                    rresp_d  = addr_ok ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d = 1'b1;
                    state_d  = RD_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    bresp_d  = addr_ok ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d = 1'b1;
                    state_d  = WR_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_rd_q <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_rd_q <= last_rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            bvalid_q  <= bvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rvalid = rvalid_q;
    assign bresp  = bresp_q;
    assign bvalid = bvalid_q;
endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench for axi_lite_sram at LAT=2: latency, strobes, arbitration, decode, stalls, reset.
module tb_axi_lite_sram;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_sram #(.BASE(32'h8000_0000), .DEPTH(4096), .LAT(2)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // lat = rising edges from the handshake edge until bvalid is seen; 99 on timeout.
    task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                             output int lat, output logic [1:0] resp);
        int k;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        k = 0;
        #1;
        while (!awready && k < 50) begin @(negedge clk); #1; k++; end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
        if (lat >= 50) lat = 99;
        resp = bresp;
    endtask

    task automatic axi_read(input logic [31:0] a, output int lat,
                            output logic [63:0] d, output logic [1:0] resp);
        int k;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        k = 0;
        #1;
        while (!arready && k < 50) begin @(negedge clk); #1; k++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
        if (lat >= 50) lat = 99;
        d = rdata; resp = rresp;
    endtask

    task automatic test_reset_contention();
        int g, cyc;
        logic [5:0] got;
        logic both;
        rst = 1'b0;
        araddr = 32'h8000_0208; awaddr = 32'h8000_0200; wdata = 64'h1; wstrb = 8'hFF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ar/aw/w/rv/bv=%b required 00000",
                     {arready, awready, wready, rvalid, bvalid});
        end
        checks++;
        if (rdata !== 64'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
            failures++;
            $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b required 0/00/00", rdata, rresp, bresp);
        end
        rst = 1'b1;
        #1;
        g = 0; cyc = 0; got = '0; both = 1'b0;
        while (g < 6 && cyc < 200) begin
            if (arready && awready) both = 1'b1;
            if (arready || awready) begin got[g] = arready; g++; end
            @(negedge clk); #1; cyc++;
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (g != 6 || got !== 6'b101010) begin
            failures++;
            $display("FAIL grant_order: grants=%0d seq(bit0 first,1=R)=%b required 6 / 101010", g, got);
        end
        checks++;
        if (both) begin
            failures++;
            $display("FAIL grant_exclusive: arready and awready high together, required never");
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat; logic [1:0] resp; logic [63:0] d;
        axi_write(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, lat, resp);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL wr_latency: got %0d required 3", lat); end
        checks++;
        if (resp !== 2'b00) begin failures++; $display("FAIL wr_bresp: got %b required 00", resp); end
        axi_read(32'h8000_0010, lat, d, resp);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d required 3", lat); end
        checks++;
        if (d !== 64'h1122_3344_5566_7788) begin
            failures++; $display("FAIL rd_data: got %h required 1122334455667788", d);
        end
        checks++;
        if (resp !== 2'b00) begin failures++; $display("FAIL rd_rresp: got %b required 00", resp); end
    endtask

    task automatic test_strobe();
        int lat; logic [1:0] resp; logic [63:0] d;
        axi_write(32'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, lat, resp);
        axi_read(32'h8000_0010, lat, d, resp);
        checks++;
        if (d !== 64'h1122_3344_AAAA_AAAA) begin
            failures++; $display("FAIL strb_0f: got %h required 11223344aaaaaaaa", d);
        end
        axi_write(32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, lat, resp);
        checks++;
        if (resp !== 2'b00) begin failures++; $display("FAIL strb_00_bresp: got %b required 00", resp); end
        axi_read(32'h8000_0015, lat, d, resp);
        checks++;
        if (d !== 64'h1122_3344_AAAA_AAAA) begin
            failures++; $display("FAIL strb_00_unaligned: got %h required 11223344aaaaaaaa", d);
        end
    endtask

    task automatic test_decode();
        int lat; logic [1:0] resp; logic [63:0] d;
        axi_write(32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, resp);
        axi_read(32'h7FFF_FFF8, lat, d, resp);
        checks++;
        if (resp !== 2'b10 || d !== 64'h0) begin
            failures++; $display("FAIL rd_below_base: rresp=%b rdata=%h required 10/0", resp, d);
        end
        axi_write(32'h8000_8000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, lat, resp);
        checks++;
        if (resp !== 2'b10) begin failures++; $display("FAIL wr_above_top: bresp=%b required 10", resp); end
        axi_read(32'h8000_0000, lat, d, resp);
        checks++;
        if (d !== 64'h0123_4567_89AB_CDEF || resp !== 2'b00) begin
            failures++; $display("FAIL base_unchanged: rdata=%h rresp=%b required 0123456789abcdef/00", d, resp);
        end
        axi_write(32'h8000_7FF8, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, lat, resp);
        axi_read(32'h8000_7FF8, lat, d, resp);
        checks++;
        if (d !== 64'h5A5A_5A5A_5A5A_5A5A || resp !== 2'b00) begin
            failures++; $display("FAIL last_word: rdata=%h rresp=%b required 5a5a5a5a5a5a5a5a/00", d, resp);
        end
    endtask

    task automatic test_stall();
        int lat; logic [1:0] resp; logic [63:0] d;
        logic bad;
        axi_write(32'h8000_0080, 64'hCAFE_F00D_1234_5678, 8'hFF, lat, resp);
        rready = 1'b0;
        axi_read(32'h8000_0080, lat, d, resp);
        araddr = 32'h8000_0088; arvalid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!rvalid || rdata !== 64'hCAFE_F00D_1234_5678 || arready) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL r_stall: rvalid=%b rdata=%h arready=%b required 1/cafef00d12345678/0",
                                 rvalid, rdata, arready);
        end
        rready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            failures++; $display("FAIL r_release: arready=%b rvalid=%b required 1/0", arready, rvalid);
        end
        arvalid = 1'b0;
        bready = 1'b0;
        axi_write(32'h8000_0090, 64'h1, 8'hFF, lat, resp);
        awaddr = 32'h8000_0098; awvalid = 1'b1; wvalid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!bvalid || bresp !== 2'b00 || awready || wready) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL b_stall: bvalid=%b bresp=%b awready=%b required 1/00/0", bvalid, bresp, awready);
        end
        bready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            failures++; $display("FAIL b_release: awready=%b bvalid=%b required 1/0", awready, bvalid);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; logic [1:0] resp; logic [63:0] d;
        axi_write(32'h8000_0040, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, lat, resp);
        axi_read(32'h8000_0040, lat, d, resp);
        @(negedge clk);
        awaddr = 32'h8000_0040; wdata = 64'h7777_7777_7777_7777; wstrb = 8'hFF;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b1) begin failures++; $display("FAIL mid_grant: awready=%b required 1", awready); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        arvalid = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0 || rdata !== 64'h0 ||
            rresp !== 2'b00 || bresp !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset_outputs: ar/aw/w/rv/bv=%b rdata=%h rresp=%b bresp=%b required 00000/0/00/00",
                     {arready, awready, wready, rvalid, bvalid}, rdata, rresp, bresp);
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        axi_read(32'h8000_0040, lat, d, resp);
        checks++;
        if (d !== 64'h0F0E_0D0C_0B0A_0908) begin
            failures++; $display("FAIL mid_reset_no_commit: got %h required 0f0e0d0c0b0a0908", d);
        end
    endtask

    initial begin
        test_reset_contention();
        test_write_read();
        test_strobe();
        test_decode();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
